// File: rtl/bus_ctrl_pkg.sv
// Shared types for the two-core coherence bus controller: FSM states,
// RAM status codes and request classes.
package bus_ctrl_pkg;

   typedef enum logic [3:0] {
      IDLE,
      IREAD,
      WB0,
      WB1,
      SNOOP,
      C2C0,
      C2C1,
      LD0,
      LD1,
      INV
   } state_t;

   typedef enum logic [1:0] {
      RS_FREE   = 2'd0,
      RS_BUSY   = 2'd1,
      RS_ACCESS = 2'd2,
      RS_ERROR  = 2'd3
   } ramstate_t;

   // Listed from highest to lowest priority.
   typedef enum logic [1:0] {
      CLS_WB,
      CLS_FETCH,
      CLS_UPG,
      CLS_IREAD
   } cls_t;

endpackage

// File: rtl/rr_arbiter.sv
// Two-requester round-robin arbiter. The `last` bit names the core that
// wins the next tie.
module rr_arbiter (
   input  logic       CLK,
   input  logic       RST,
   input  logic [1:0] req,
   input  logic       en,
   output logic       gnt
);

   logic last;

   always_comb begin
      if (req == 2'b11) gnt = last;
      else              gnt = req[1];
   end

   // Only contested grants move `last`, so an uncontested grant does not
   // cost the other core its turn at the next collision.
   always_ff @(posedge CLK) begin
      if (RST)                         last <= 1'b0;
      else if (en && (req == 2'b11))   last <= ~gnt;
   end

endmodule

// File: rtl/coherence_bus_control.sv
// Shared RAM arbiter and MSI snoop sequencer for a two-core system, with
// cache-to-cache forwarding of modified blocks during writeback.
module coherence_bus_control
   import bus_ctrl_pkg::*;
#(
   parameter int CPUS   = 2,
   parameter int WORD_W = 32
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic [CPUS-1:0]   iREN,
   input  logic [WORD_W-1:0] iaddr [CPUS],
   output logic [CPUS-1:0]   iwait,
   output logic [WORD_W-1:0] iload [CPUS],
   input  logic [CPUS-1:0]   dREN,
   input  logic [CPUS-1:0]   dWEN,
   input  logic [WORD_W-1:0] daddr [CPUS],
   input  logic [WORD_W-1:0] dstore [CPUS],
   output logic [CPUS-1:0]   dwait,
   output logic [WORD_W-1:0] dload [CPUS],
   input  logic [CPUS-1:0]   cctrans,
   input  logic [CPUS-1:0]   ccwrite,
   output logic [CPUS-1:0]   ccwait,
   output logic [CPUS-1:0]   ccinv,
   output logic [WORD_W-1:0] ccsnoopaddr [CPUS],
   output logic              ramREN,
   output logic              ramWEN,
   output logic [WORD_W-1:0] ramaddr,
   output logic [WORD_W-1:0] ramstore,
   input  logic [WORD_W-1:0] ramload,
   input  logic [1:0]        ramstate
);

   state_t     state, next_state;
   logic       req;
   cls_t       cls;
   logic       o;
   logic       access;
   logic       snoop_inv;
   logic       grant;
   logic       gnt;
   cls_t       grant_cls;
   logic [1:0] wb_req, fetch_req, upg_req, ird_req, arb_req;

   assign o         = ~req;
   assign access    = (ramstate == RS_ACCESS);
   assign snoop_inv = (cls == CLS_UPG) | ccwrite[req];
   assign grant     = (state == IDLE) && (|arb_req);

   // Arbitrate only among the highest non-empty class.
   always_comb begin
      wb_req    = dWEN & ~cctrans;
      fetch_req = dREN;
      upg_req   = cctrans & ccwrite & ~dREN & ~dWEN;
      ird_req   = iREN;
      arb_req   = 2'b00;
      grant_cls = CLS_IREAD;
      if (|wb_req) begin
         arb_req   = wb_req;
         grant_cls = CLS_WB;
      end else if (|fetch_req) begin
         arb_req   = fetch_req;
         grant_cls = CLS_FETCH;
      end else if (|upg_req) begin
         arb_req   = upg_req;
         grant_cls = CLS_UPG;
      end else begin
         arb_req   = ird_req;
         grant_cls = CLS_IREAD;
      end
   end

   rr_arbiter u_arb (
      .CLK (CLK),
      .RST (RST),
      .req (arb_req),
      .en  (grant),
      .gnt (gnt)
   );

   always_ff @(posedge CLK) begin
      if (RST) begin
         state <= IDLE;
         req   <= 1'b0;
         cls   <= CLS_IREAD;
      end else begin
         state <= next_state;
         if (grant) begin
            req <= gnt;
            cls <= grant_cls;
         end
      end
   end

   // Outputs are held at their idle values while RST is high so an
   // in-flight RAM strobe drops in the reset cycle itself.
   always_comb begin
      next_state = state;
      iwait      = '1;
      dwait      = '1;
      ccwait     = '0;
      ccinv      = '0;
      ramREN     = 1'b0;
      ramWEN     = 1'b0;
      ramaddr    = '0;
      ramstore   = '0;
      for (int c = 0; c < CPUS; c++) begin
         iload[c]       = '0;
         dload[c]       = '0;
         ccsnoopaddr[c] = '0;
      end

      if (!RST) begin
         case (state)
            IDLE: begin
               if (|arb_req) begin
                  case (grant_cls)
                     CLS_WB:    next_state = WB0;
                     CLS_FETCH: next_state = SNOOP;
                     CLS_UPG:   next_state = INV;
                     default:   next_state = IREAD;
                  endcase
               end
            end
            IREAD: begin
               ramREN     = 1'b1;
               ramaddr    = iaddr[req];
               iload[req] = ramload;
               iwait[req] = ~access;
               if (access) next_state = IDLE;
            end
            WB0, WB1: begin
               ramWEN     = 1'b1;
               ramaddr    = daddr[req];
               ramstore   = dstore[req];
               dwait[req] = ~access;
               if (access) next_state = (state == WB0) ? WB1 : IDLE;
            end
            SNOOP: begin
               next_state = dWEN[o] ? C2C0 : LD0;
            end
            C2C0, C2C1: begin
               ramWEN     = 1'b1;
               ramaddr    = daddr[o];
               ramstore   = dstore[o];
               dload[req] = dstore[o];
               dwait[req] = ~access;
               dwait[o]   = ~access;
               if (access) next_state = (state == C2C0) ? C2C1 : IDLE;
            end
            LD0, LD1: begin
               ramREN     = 1'b1;
               ramaddr    = daddr[req];
               dload[req] = ramload;
               dwait[req] = ~access;
               if (access) next_state = (state == LD0) ? LD1 : IDLE;
            end
            INV: begin
               dwait[req] = 1'b0;
               next_state = IDLE;
            end
            default: next_state = IDLE;
         endcase

         if (state inside {SNOOP, C2C0, C2C1, LD0, LD1, INV}) begin
            ccwait[o]      = 1'b1;
            ccinv[o]       = snoop_inv;
            ccsnoopaddr[o] = daddr[req];
         end
      end
   end

endmodule

// File: tb/tb_coherence_bus_control.sv
// Directed-vector bench for coherence_bus_control; the bench plays both
// cache pairs and the RAM model.
module tb_coherence_bus_control;

   localparam int CPUS   = 2;
   localparam int WORD_W = 32;

   localparam logic [1:0] FREE   = 2'd0;
   localparam logic [1:0] ACCESS = 2'd2;
   localparam logic [1:0] ERROR  = 2'd3;

   logic              CLK = 1'b0;
   logic              RST;
   logic [CPUS-1:0]   iREN;
   logic [WORD_W-1:0] iaddr [CPUS];
   logic [CPUS-1:0]   iwait;
   logic [WORD_W-1:0] iload [CPUS];
   logic [CPUS-1:0]   dREN, dWEN;
   logic [WORD_W-1:0] daddr [CPUS];
   logic [WORD_W-1:0] dstore [CPUS];
   logic [CPUS-1:0]   dwait;
   logic [WORD_W-1:0] dload [CPUS];
   logic [CPUS-1:0]   cctrans, ccwrite;
   logic [CPUS-1:0]   ccwait, ccinv;
   logic [WORD_W-1:0] ccsnoopaddr [CPUS];
   logic              ramREN, ramWEN;
   logic [WORD_W-1:0] ramaddr, ramstore;
   logic [WORD_W-1:0] ramload;
   logic [1:0]        ramstate;

   int total = 0;
   int bad   = 0;

   coherence_bus_control #(.CPUS(CPUS), .WORD_W(WORD_W)) dut (
      .CLK         (CLK),
      .RST         (RST),
      .iREN        (iREN),
      .iaddr       (iaddr),
      .iwait       (iwait),
      .iload       (iload),
      .dREN        (dREN),
      .dWEN        (dWEN),
      .daddr       (daddr),
      .dstore      (dstore),
      .dwait       (dwait),
      .dload       (dload),
      .cctrans     (cctrans),
      .ccwrite     (ccwrite),
      .ccwait      (ccwait),
      .ccinv       (ccinv),
      .ccsnoopaddr (ccsnoopaddr),
      .ramREN      (ramREN),
      .ramWEN      (ramWEN),
      .ramaddr     (ramaddr),
      .ramstore    (ramstore),
      .ramload     (ramload),
      .ramstate    (ramstate)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Inputs are driven 1 time unit after the rising edge; checks follow a
   // further unit later, well clear of the next edge.
   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   initial begin
      RST      = 1'b1;
      iREN     = '0;
      dREN     = '0;
      dWEN     = '0;
      cctrans  = '0;
      ccwrite  = '0;
      ramload  = '0;
      ramstate = FREE;
      for (int c = 0; c < CPUS; c++) begin
         iaddr[c]  = '0;
         daddr[c]  = '0;
         dstore[c] = '0;
      end
      step();
      step();

      // Reset state
      RST = 1'b0;
      settle();
      chk("rst_iwait",  32'(iwait),  32'h3);
      chk("rst_dwait",  32'(dwait),  32'h3);
      chk("rst_ccwait", 32'(ccwait), 32'h0);
      chk("rst_ccinv",  32'(ccinv),  32'h0);
      chk("rst_ramREN", 32'(ramREN), 32'h0);
      chk("rst_ramWEN", 32'(ramWEN), 32'h0);
      chk("rst_ramaddr", ramaddr, 32'h0);
      chk("rst_iload0",  iload[0], 32'h0);
      chk("rst_dload1",  dload[1], 32'h0);
      step();

      // Icache word: IDLE then IREAD with ACCESS
      iREN[0]  = 1'b1;
      iaddr[0] = 32'h40;
      ramload  = 32'hDEAD;
      settle();
      chk("ird_idle_iwait",  32'(iwait),  32'h3);
      chk("ird_idle_ramREN", 32'(ramREN), 32'h0);
      step();
      ramstate = ACCESS;
      settle();
      chk("ird_iwait",   32'(iwait),  32'h2);
      chk("ird_iload0",  iload[0],    32'hDEAD);
      chk("ird_ramREN",  32'(ramREN), 32'h1);
      chk("ird_ramaddr", ramaddr,     32'h40);
      iREN[0] = 1'b0;
      step();
      ramstate = FREE;
      settle();
      chk("ird_done_ramREN", 32'(ramREN), 32'h0);
      chk("ird_done_iwait",  32'(iwait),  32'h3);

      // dREN collision: core 0 first
      dREN     = 2'b11;
      daddr[0] = 32'h300;
      daddr[1] = 32'h400;
      settle();
      chk("col1_idle_dwait", 32'(dwait), 32'h3);
      step();
      settle();
      chk("col1_snoop_ccwait", 32'(ccwait), 32'h2);
      chk("col1_snoop_addr",   ccsnoopaddr[1], 32'h300);
      chk("col1_snoop_ccinv",  32'(ccinv), 32'h0);
      step();
      ramstate = ACCESS;
      ramload  = 32'h11;
      settle();
      chk("col1_ld0_ramREN",  32'(ramREN), 32'h1);
      chk("col1_ld0_ramaddr", ramaddr, 32'h300);
      chk("col1_ld0_dwait",   32'(dwait), 32'h2);
      chk("col1_ld0_dload0",  dload[0], 32'h11);
      chk("col1_ld0_ccwait",  32'(ccwait), 32'h2);
      step();
      daddr[0] = 32'h304;
      ramload  = 32'h22;
      settle();
      chk("col1_ld1_ramaddr", ramaddr, 32'h304);
      chk("col1_ld1_dload0",  dload[0], 32'h22);
      chk("col1_ld1_ccwait",  32'(ccwait), 32'h2);
      dREN[0] = 1'b0;
      step();

      // Core 1 is served next
      ramstate = FREE;
      settle();
      chk("col2_idle_dwait", 32'(dwait), 32'h3);
      step();
      settle();
      chk("col2_snoop_ccwait", 32'(ccwait), 32'h1);
      chk("col2_snoop_addr",   ccsnoopaddr[0], 32'h400);
      step();
      ramstate = ACCESS;
      settle();
      chk("col2_ld0_ramaddr", ramaddr, 32'h400);
      chk("col2_ld0_dwait",   32'(dwait), 32'h1);
      step();
      daddr[1] = 32'h404;
      settle();
      chk("col2_ld1_ramaddr", ramaddr, 32'h404);
      dREN[1] = 1'b0;
      step();

      // Repeated collision: core 1 wins this time
      ramstate = FREE;
      dREN     = 2'b11;
      daddr[0] = 32'h300;
      daddr[1] = 32'h400;
      step();
      settle();
      chk("col3_snoop_ccwait", 32'(ccwait), 32'h1);
      chk("col3_snoop_addr",   ccsnoopaddr[0], 32'h400);
      step();
      ramstate = ACCESS;
      settle();
      chk("col3_ld0_ramaddr", ramaddr, 32'h400);
      step();
      dREN = 2'b00;
      step();
      ramstate = FREE;
      settle();
      chk("col3_done_ccwait", 32'(ccwait), 32'h0);

      // Cache-to-cache: core 0 BusRdX, core 1 owns the block modified
      dREN[0]    = 1'b1;
      ccwrite[0] = 1'b1;
      daddr[0]   = 32'h100;
      step();
      dWEN[1]   = 1'b1;
      daddr[1]  = 32'h100;
      dstore[1] = 32'hA5A5;
      settle();
      chk("c2c_snoop_ccwait", 32'(ccwait), 32'h2);
      chk("c2c_snoop_ccinv",  32'(ccinv),  32'h2);
      chk("c2c_snoop_addr",   ccsnoopaddr[1], 32'h100);
      chk("c2c_snoop_ram",    32'({ramREN, ramWEN}), 32'h0);
      step();
      ramstate = ACCESS;
      settle();
      chk("c2c0_ramWEN",   32'(ramWEN), 32'h1);
      chk("c2c0_ramaddr",  ramaddr,  32'h100);
      chk("c2c0_ramstore", ramstore, 32'hA5A5);
      chk("c2c0_dload0",   dload[0], 32'hA5A5);
      chk("c2c0_dwait",    32'(dwait), 32'h0);
      chk("c2c0_ccwait",   32'(ccwait), 32'h2);
      step();
      daddr[0]  = 32'h104;
      daddr[1]  = 32'h104;
      dstore[1] = 32'h5A5A;
      settle();
      chk("c2c1_ramaddr",  ramaddr,  32'h104);
      chk("c2c1_ramstore", ramstore, 32'h5A5A);
      chk("c2c1_dload0",   dload[0], 32'h5A5A);
      chk("c2c1_dwait",    32'(dwait), 32'h0);
      chk("c2c1_ccinv",    32'(ccinv), 32'h2);
      dREN[0]    = 1'b0;
      ccwrite[0] = 1'b0;
      dWEN[1]    = 1'b0;
      step();
      ramstate = FREE;
      settle();
      chk("c2c_done_ccwait", 32'(ccwait), 32'h0);
      chk("c2c_done_ramWEN", 32'(ramWEN), 32'h0);

      // Upgrade from core 1
      cctrans[1] = 1'b1;
      ccwrite[1] = 1'b1;
      daddr[1]   = 32'h200;
      step();
      settle();
      chk("upg_ccwait", 32'(ccwait), 32'h1);
      chk("upg_ccinv",  32'(ccinv),  32'h1);
      chk("upg_addr",   ccsnoopaddr[0], 32'h200);
      chk("upg_dwait",  32'(dwait), 32'h1);
      chk("upg_ram",    32'({ramREN, ramWEN}), 32'h0);
      cctrans[1] = 1'b0;
      ccwrite[1] = 1'b0;
      step();
      settle();
      chk("upg_done_ccinv", 32'(ccinv), 32'h0);
      chk("upg_done_dwait", 32'(dwait), 32'h3);

      // Writeback beats a pending icache read; ERROR retries the word
      dWEN[0]   = 1'b1;
      daddr[0]  = 32'h500;
      dstore[0] = 32'h77;
      iREN[1]   = 1'b1;
      iaddr[1]  = 32'h80;
      ramstate  = ERROR;
      step();
      for (int k = 0; k < 3; k++) begin
         settle();
         chk("wb_err_ramWEN",  32'(ramWEN), 32'h1);
         chk("wb_err_ramaddr", ramaddr, 32'h500);
         chk("wb_err_dwait",   32'(dwait), 32'h3);
         chk("wb_err_iwait",   32'(iwait), 32'h3);
         step();
      end
      ramstate = ACCESS;
      settle();
      chk("wb0_dwait",    32'(dwait), 32'h2);
      chk("wb0_ramstore", ramstore, 32'h77);
      step();
      daddr[0]  = 32'h504;
      dstore[0] = 32'h88;
      settle();
      chk("wb1_ramaddr",  ramaddr, 32'h504);
      chk("wb1_ramstore", ramstore, 32'h88);
      chk("wb1_dwait",    32'(dwait), 32'h2);
      dWEN[0] = 1'b0;
      step();
      ramstate = FREE;
      settle();
      chk("wb_idle_ramREN", 32'(ramREN), 32'h0);
      chk("wb_idle_iwait",  32'(iwait), 32'h3);
      step();
      ramstate = ACCESS;
      ramload  = 32'h99;
      settle();
      chk("ird1_iwait",   32'(iwait), 32'h1);
      chk("ird1_iload1",  iload[1], 32'h99);
      chk("ird1_ramaddr", ramaddr, 32'h80);
      iREN[1] = 1'b0;
      step();

      // RST pulsed during LD1
      ramstate = FREE;
      dREN[1]  = 1'b1;
      daddr[1] = 32'h600;
      step();
      step();
      ramstate = ACCESS;
      step();
      settle();
      chk("rst_ld1_ramREN", 32'(ramREN), 32'h1);
      RST = 1'b1;
      settle();
      chk("rst_ld1_strobe", 32'(ramREN), 32'h0);
      chk("rst_ld1_dwait",  32'(dwait), 32'h3);
      step();
      RST      = 1'b0;
      dREN[1]  = 1'b0;
      ramstate = FREE;
      settle();
      chk("post_rst_ramREN", 32'(ramREN), 32'h0);
      chk("post_rst_iwait",  32'(iwait), 32'h3);
      chk("post_rst_dwait",  32'(dwait), 32'h3);
      chk("post_rst_ccwait", 32'(ccwait), 32'h0);
      step();
      settle();
      chk("post_rst_idle_ram", 32'({ramREN, ramWEN}), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
